onchip_sram_dp: RTL and testbench
=================================

ONCHIP_SRAM_DP -- requirements
Module: onchip_sram_dp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: word width in bits; multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 8: word address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the array after reset, 0 = no fill.
REQ-004 SHALL derive BE_W = DATA_W/8 for byteenable width.
REQ-005 SHALL have exactly one clock, clk (input, 1): all logic on its rising edge.
REQ-006 SHALL have reset_n (input, 1): synchronous, active-low reset.
REQ-007 SHALL provide, per port p in {a,b}: address_p (in, ADDR_W), byteenable_p (in, BE_W), chipselect_p (in, 1), read_p (in, 1), write_p (in, 1), writedata_p (in, DATA_W).
REQ-008 SHALL provide, per port p: readdata_p (out, DATA_W), readdatavalid_p (out, 1), waitrequest_p (out, 1).
REQ-009 SHALL provide init_done (out, 1): high once the array is usable.
REQ-010 SHALL provide collision_cnt (out, 16): saturating count of same-address collision cycles.

Function
REQ-011 SHALL implement a two-state FSM, CLEAR and RUN; after reset it enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-012 SHALL, in CLEAR, write all-zero words to addresses 0..DEPTH-1 at one word per cycle, then enter RUN; CLEAR lasts exactly DEPTH cycles.
REQ-013 SHALL hold waitrequest_a/b high and init_done low in CLEAR; in RUN, waitrequest_a/b are low and init_done is high.
REQ-014 SHALL accept a transfer on port p only when chipselect_p=1 and waitrequest_p=0; no other cycle is a transfer.
REQ-015 SHALL, for an accepted write, update only the byte lanes whose byteenable_p bit is 1; no readdatavalid is produced.
REQ-016 SHALL, for an accepted read, return the addressed word on readdata_p with readdatavalid_p high for one cycle, 1 cycle after acceptance; byteenable is ignored for reads.
REQ-017 SHALL sustain one accepted read per cycle per port, fully pipelined.
REQ-018 SHALL treat read_p=1 and write_p=1 together on one port as a write only, with no read response.
REQ-019 SHALL, when both ports write the same address in one cycle, take port A data on every lane A enables, and port B data on lanes that only B enables.
REQ-020 SHALL, when one port reads the address the other port writes in the same cycle, return the old contents (read-before-write).
REQ-021 SHALL increment collision_cnt by 1 in each RUN cycle where both ports are accepted at equal addresses and at least one is a write; it saturates at 16'hFFFF.
REQ-022 SHALL keep readdata_p at its last value when readdatavalid_p is low.

Reset
REQ-023 SHALL, while reset_n=0, drive readdata_a/b=0, readdatavalid_a/b=0, waitrequest_a/b=1, init_done=0 and collision_cnt=0.
REQ-024 SHALL, when reset is asserted mid-CLEAR, abort the fill and restart it at address 0 after release.
REQ-025 SHALL, when reset is asserted with reads in flight, discard them; no readdatavalid is issued after release.
REQ-026 SHALL NOT guarantee array contents across reset when CLEAR_ON_RESET=0.

Configuration
REQ-027 SHALL recognise the macro ONCHIP_SRAM_DP_OUTREG_EN.
REQ-028 SHALL, when ONCHIP_SRAM_DP_OUTREG_EN is defined, add an output register stage per port: read latency becomes 2 cycles, throughput is unchanged, and readdatavalid is delayed to match.
REQ-029 SHALL, when ONCHIP_SRAM_DP_OUTREG_EN is undefined, use a read latency of 1 cycle, as in REQ-016.

Verification
REQ-030 Reset, then hold idle, with CLEAR_ON_RESET=1 and ADDR_W=8 -> waitrequest high for exactly 256 cycles, then init_done=1; a read of address 8'h7F returns 32'h0.
REQ-031 Port A writes 32'hDEADBEEF to 8'h10 with byteenable 4'b0101, then port B reads 8'h10 -> readdata_b=32'h00AD00EF, valid 1 cycle later (2 cycles with the macro).
REQ-032 Same cycle: A writes 32'h11111111 with byteenable 4'b0011 and B writes 32'h22222222 with byteenable 4'b1111, both to 8'h20 -> a later read returns 32'h22221111 and collision_cnt=1.
REQ-033 Same cycle: A reads 8'h30 (holding 32'h5) while B writes 32'h9 to 8'h30 -> readdata_a=32'h5; a following read returns 32'h9.
REQ-034 Back-to-back reads on both ports over 8'h00..8'h0F -> 16 valid pulses per port in consecutive cycles, in order, with no gaps.
REQ-035 reset_n low for 1 cycle at CLEAR cycle 100 -> fill restarts, and init_done rises 256 cycles after release.

Source files
------------

// File: rtl/onchip_sram_dp.sv
// Dual-port, byte-enabled on-chip SRAM with a post-reset zero fill and a same-address collision counter.
// Define ONCHIP_SRAM_DP_OUTREG_EN to add an output register stage per port (read latency 2 instead of 1).
module onchip_sram_dp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address_a,
  input  logic [DATA_W/8-1:0] byteenable_a,
  input  logic                chipselect_a,
  input  logic                read_a,
  input  logic                write_a,
  input  logic [DATA_W-1:0]   writedata_a,
  output logic [DATA_W-1:0]   readdata_a,
  output logic                readdatavalid_a,
  output logic                waitrequest_a,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W/8-1:0] byteenable_b,
  input  logic                chipselect_b,
  input  logic                read_b,
  input  logic                write_b,
  input  logic [DATA_W-1:0]   writedata_b,
  output logic [DATA_W-1:0]   readdata_b,
  output logic                readdatavalid_b,
  output logic                waitrequest_b,
  output logic                init_done,
  output logic [15:0]         collision_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              w_busy;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [ADDR_W-1:0] w_addr  [2];
  logic [BE_W-1:0]   w_be    [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic [1:0]        w_acc;
  logic [1:0]        w_wr;
  logic [1:0]        w_rd;
  logic              w_coll;

  logic [DATA_W-1:0] r_rd_data [2];
  logic [1:0]        r_rd_valid;
  logic [DATA_W-1:0] w_q_data  [2];
  logic [1:0]        w_q_valid;
  logic [15:0]       r_coll_cnt;

  assign w_addr[0]  = address_a;
  assign w_addr[1]  = address_b;
  assign w_be[0]    = byteenable_a;
  assign w_be[1]    = byteenable_b;
  assign w_wdata[0] = writedata_a;
  assign w_wdata[1] = writedata_b;

  assign w_busy = (r_state == ST_CLEAR) || !reset_n;

  always_comb begin
    w_acc = {chipselect_b & (read_b | write_b), chipselect_a & (read_a | write_a)} & {2{~w_busy}};
    w_wr  = w_acc & {write_b, write_a};
    w_rd  = w_acc & {read_b, read_a} & ~{write_b, write_a};
  end

  assign w_coll = (&w_acc) && (address_a == address_b) && (|w_wr);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    else          r_state <= w_state_next;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_state_next = ST_RUN;
      ST_RUN:   w_state_next = ST_RUN;
      default:  w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                  r_clr_addr <= '0;
    else if (r_state == ST_CLEAR)  r_clr_addr <= r_clr_addr + ADDR_W'(1);
  end

  // NOTE: the array has no reset branch; a reset would turn it into flops. Zeroing is done by the fill walk.
  // Port B lanes are written first so that port A wins every lane both ports enable.
  always_ff @(posedge clk) begin
    if (reset_n && r_state == ST_CLEAR) r_mem[r_clr_addr] <= '0;
    for (int p = 1; p >= 0; p--) begin
      if (w_wr[p]) begin
        for (int l = 0; l < BE_W; l++) begin
          if (w_be[p][l]) r_mem[w_addr[p]][l*8 +: 8] <= w_wdata[p][l*8 +: 8];
        end
      end
    end
  end

  // NOTE: non-blocking writes above mean this read sees the pre-write word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_valid <= '0;
      for (int p = 0; p < 2; p++) r_rd_data[p] <= '0;
    end else begin
      r_rd_valid <= w_rd;
      for (int p = 0; p < 2; p++) begin
        if (w_rd[p]) r_rd_data[p] <= r_mem[w_addr[p]];
      end
    end
  end

`ifdef ONCHIP_SRAM_DP_OUTREG_EN
  logic [DATA_W-1:0] r_out_data [2];
  logic [1:0]        r_out_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= '0;
      for (int p = 0; p < 2; p++) r_out_data[p] <= '0;
    end else begin
      r_out_valid <= r_rd_valid;
      for (int p = 0; p < 2; p++) begin
        if (r_rd_valid[p]) r_out_data[p] <= r_rd_data[p];
      end
    end
  end

  assign w_q_data[0] = r_out_data[0];
  assign w_q_data[1] = r_out_data[1];
  assign w_q_valid   = r_out_valid;
`else
  assign w_q_data[0] = r_rd_data[0];
  assign w_q_data[1] = r_rd_data[1];
  assign w_q_valid   = r_rd_valid;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n)                              r_coll_cnt <= '0;
    else if (w_coll && r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
  end

  assign readdata_a      = w_q_data[0];
  assign readdata_b      = w_q_data[1];
  assign readdatavalid_a = w_q_valid[0];
  assign readdatavalid_b = w_q_valid[1];
  assign waitrequest_a   = w_busy;
  assign waitrequest_b   = w_busy;
  assign init_done       = !w_busy;
  assign collision_cnt   = r_coll_cnt;

endmodule

// File: tb/tb_onchip_sram_dp.sv
// Self-checking bench for onchip_sram_dp: directed vector table, reset/fill sequences and a
// randomized dual-port phase scored against a word-array reference model.
`timescale 1ns/1ps
module tb_onchip_sram_dp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
`ifdef ONCHIP_SRAM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } op_t;

  typedef struct {
    string       name;
    op_t         a;
    op_t         b;
    logic        ev_a;
    logic [31:0] ed_a;
    logic        ev_b;
    logic [31:0] ed_b;
    logic [15:0] ecoll;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  localparam op_t IDLE = '0;
  localparam int  NV   = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  address_a, address_b;
  logic [3:0]  byteenable_a, byteenable_b;
  logic        chipselect_a, chipselect_b, read_a, read_b, write_a, write_b;
  logic [31:0] writedata_a, writedata_b, readdata_a, readdata_b;
  logic        readdatavalid_a, readdatavalid_b, waitrequest_a, waitrequest_b, init_done;
  logic [15:0] collision_cnt;

  onchip_sram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .address_a(address_a), .byteenable_a(byteenable_a), .chipselect_a(chipselect_a),
    .read_a(read_a), .write_a(write_a), .writedata_a(writedata_a),
    .readdata_a(readdata_a), .readdatavalid_a(readdatavalid_a), .waitrequest_a(waitrequest_a),
    .address_b(address_b), .byteenable_b(byteenable_b), .chipselect_b(chipselect_b),
    .read_b(read_b), .write_b(write_b), .writedata_b(writedata_b),
    .readdata_b(readdata_b), .readdatavalid_b(readdatavalid_b), .waitrequest_b(waitrequest_b),
    .init_done(init_done), .collision_cnt(collision_cnt)
  );

  always #5 clk = ~clk;

  int          n_pass, n_total, cyc;
  logic [31:0] m_mem [DEPTH];
  int          m_coll;
  exp_t        q_a[$];
  exp_t        q_b[$];
  bit          sb_on;
  int          vc_a, vc_b, first_a, last_a_cyc, first_b, last_b_cyc;
  vec_t        vecs [NV];
  logic [31:0] last_a, last_b;
  op_t         ra, rb;
  int          n_clear, spurious;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic op_t mk_wr(input logic [7:0] addr, input logic [3:0] be, input logic [31:0] wd);
    return '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: addr, be: be, wd: wd};
  endfunction

  function automatic op_t mk_rd(input logic [7:0] addr);
    return '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: addr, be: 4'h0, wd: 32'h0};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = wd[l*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive both ports for the coming edge and advance the reference model by one transaction cycle.
  task automatic drive(input op_t a, input op_t b);
    logic acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
    logic [31:0] old_a, old_b;
    address_a = a.addr; byteenable_a = a.be; chipselect_a = a.cs;
    read_a = a.rd; write_a = a.wr; writedata_a = a.wd;
    address_b = b.addr; byteenable_b = b.be; chipselect_b = b.cs;
    read_b = b.rd; write_b = b.wr; writedata_b = b.wd;
    acc_a = a.cs & (a.rd | a.wr);
    acc_b = b.cs & (b.rd | b.wr);
    wr_a  = acc_a & a.wr;
    wr_b  = acc_b & b.wr;
    rd_a  = acc_a & a.rd & !a.wr;
    rd_b  = acc_b & b.rd & !b.wr;
    old_a = m_mem[a.addr];
    old_b = m_mem[b.addr];
    if (sb_on && rd_a) q_a.push_back('{data: old_a, due: cyc + LAT});
    if (sb_on && rd_b) q_b.push_back('{data: old_b, due: cyc + LAT});
    if (wr_b) m_mem[b.addr] = merge(m_mem[b.addr], b.wd, b.be);
    if (wr_a) m_mem[a.addr] = merge(m_mem[a.addr], a.wd, a.be);
    if (acc_a && acc_b && a.addr == b.addr && (wr_a || wr_b) && m_coll < 65535) m_coll++;
  endtask

  task automatic sb_check();
    logic ev;
    ev = (q_a.size() > 0) && (q_a[0].due == cyc);
    check1("sb_valid_a", readdatavalid_a, ev);
    if (ev) begin
      check("sb_data_a", readdata_a, q_a[0].data);
      q_a.delete(0);
    end
    ev = (q_b.size() > 0) && (q_b[0].due == cyc);
    check1("sb_valid_b", readdatavalid_b, ev);
    if (ev) begin
      check("sb_data_b", readdata_b, q_b[0].data);
      q_b.delete(0);
    end
    if (readdatavalid_a) begin
      if (vc_a == 0) first_a = cyc;
      last_a_cyc = cyc;
      vc_a++;
    end
    if (readdatavalid_b) begin
      if (vc_b == 0) first_b = cyc;
      last_b_cyc = cyc;
      vc_b++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata_a"}, readdata_a, 32'h0);
    check({tag, "_rdata_b"}, readdata_b, 32'h0);
    check1({tag, "_valid_a"}, readdatavalid_a, 1'b0);
    check1({tag, "_valid_b"}, readdatavalid_b, 1'b0);
    check1({tag, "_wait_a"}, waitrequest_a, 1'b1);
    check1({tag, "_wait_b"}, waitrequest_b, 1'b1);
    check1({tag, "_init"}, init_done, 1'b0);
    check({tag, "_coll"}, {16'h0, collision_cnt}, 32'h0);
  endtask

  // Counts cycles with waitrequest high (bounded) and any readdatavalid seen meanwhile.
  task automatic count_clear(output int n, output int bad);
    n = 0;
    bad = 0;
    while (waitrequest_a === 1'b1 && n < 2000) begin
      if (readdatavalid_a || readdatavalid_b || waitrequest_b !== 1'b1 || init_done) bad++;
      n++;
      step();
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_coll = 0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; sb_on = 0; m_coll = 0;
    vc_a = 0; vc_b = 0; first_a = 0; first_b = 0; last_a_cyc = 0; last_b_cyc = 0;
    model_clear();

    vecs[0]  = '{"be_write",    mk_wr(8'h10, 4'b0101, 32'hDEADBEEF), IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0};
    vecs[1]  = '{"be_read",     IDLE, mk_rd(8'h10), 1'b0, 32'h0, 1'b1, 32'h00AD00EF, 16'd0};
    vecs[2]  = '{"ww_coll",     mk_wr(8'h20, 4'b0011, 32'h11111111), mk_wr(8'h20, 4'b1111, 32'h22222222),
                 1'b0, 32'h0, 1'b0, 32'h0, 16'd1};
    vecs[3]  = '{"ww_read",     mk_rd(8'h20), IDLE, 1'b1, 32'h22221111, 1'b0, 32'h0, 16'd1};
    vecs[4]  = '{"pre_write",   mk_wr(8'h30, 4'hF, 32'h5), IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 16'd1};
    vecs[5]  = '{"rbw",         mk_rd(8'h30), mk_wr(8'h30, 4'hF, 32'h9), 1'b1, 32'h5, 1'b0, 32'h0, 16'd2};
    vecs[6]  = '{"rbw_new",     IDLE, mk_rd(8'h30), 1'b0, 32'h0, 1'b1, 32'h9, 16'd2};
    vecs[7]  = '{"clear_read",  mk_rd(8'h7F), IDLE, 1'b1, 32'h0, 1'b0, 32'h0, 16'd2};
    vecs[8]  = '{"rw_both",     '{1'b1, 1'b1, 1'b1, 8'h40, 4'hF, 32'h12345678}, IDLE,
                 1'b0, 32'h0, 1'b0, 32'h0, 16'd2};
    vecs[9]  = '{"rw_read",     IDLE, mk_rd(8'h40), 1'b0, 32'h0, 1'b1, 32'h12345678, 16'd2};
    vecs[10] = '{"cs_low",      '{1'b0, 1'b0, 1'b1, 8'h41, 4'hF, 32'hFFFFFFFF}, IDLE,
                 1'b0, 32'h0, 1'b0, 32'h0, 16'd2};
    vecs[11] = '{"cs_low_read", mk_rd(8'h41), IDLE, 1'b1, 32'h0, 1'b0, 32'h0, 16'd2};
    vecs[12] = '{"rr_same",     mk_rd(8'h10), mk_rd(8'h10), 1'b1, 32'h00AD00EF, 1'b1, 32'h00AD00EF, 16'd2};
    vecs[13] = '{"ww_lanes",    mk_wr(8'h10, 4'b0001, 32'h000000BB), mk_wr(8'h10, 4'b1001, 32'hAA0000CC),
                 1'b0, 32'h0, 1'b0, 32'h0, 16'd3};
    vecs[14] = '{"ww_lanes_rd", mk_rd(8'h10), IDLE, 1'b1, 32'hAAAD00BB, 1'b0, 32'h0, 16'd3};
    vecs[15] = '{"rw_coll",     mk_rd(8'h50), '{1'b1, 1'b1, 1'b1, 8'h50, 4'hF, 32'h77},
                 1'b1, 32'h0, 1'b0, 32'h0, 16'd4};

    // Reset and initial fill.
    reset_n = 1'b0;
    drive(IDLE, IDLE);
    repeat (3) step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    count_clear(n_clear, spurious);
    check("clear_len", n_clear, 256);
    check("clear_quiet", spurious, 0);
    check1("init_done", init_done, 1'b1);
    check1("run_wait_b", waitrequest_b, 1'b0);

    // Directed vector table, each vector isolated by its read latency.
    last_a = 32'h0;
    last_b = 32'h0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].a, vecs[i].b);
      step();
      drive(IDLE, IDLE);
      repeat (LAT - 1) step();
      check1({vecs[i].name, "/valid_a"}, readdatavalid_a, vecs[i].ev_a);
      check1({vecs[i].name, "/valid_b"}, readdatavalid_b, vecs[i].ev_b);
      if (vecs[i].ev_a) last_a = vecs[i].ed_a;
      if (vecs[i].ev_b) last_b = vecs[i].ed_b;
      check({vecs[i].name, "/data_a"}, readdata_a, last_a);
      check({vecs[i].name, "/data_b"}, readdata_b, last_b);
      check({vecs[i].name, "/coll"}, {16'h0, collision_cnt}, {16'h0, vecs[i].ecoll});
    end

    // Exact read latency and single-cycle valid pulse.
    drive(mk_rd(8'h20), IDLE);
    step();
    drive(IDLE, IDLE);
    check1("lat_early", readdatavalid_a, LAT == 1);
    if (LAT == 2) step();
    check1("lat_valid", readdatavalid_a, 1'b1);
    check("lat_data", readdata_a, 32'h22221111);
    step();
    check1("lat_pulse", readdatavalid_a, 1'b0);
    check("lat_hold", readdata_a, 32'h22221111);

    // Back-to-back reads on both ports.
    sb_on = 1;
    vc_a = 0; vc_b = 0;
    for (int i = 0; i < 16; i++) begin
      drive(mk_rd(8'(i)), mk_rd(8'(15 - i)));
      step();
      sb_check();
    end
    drive(IDLE, IDLE);
    repeat (LAT + 1) begin
      step();
      sb_check();
    end
    check("b2b_cnt_a", vc_a, 16);
    check("b2b_cnt_b", vc_b, 16);
    check("b2b_span_a", last_a_cyc - first_a, 15);
    check("b2b_span_b", last_b_cyc - first_b, 15);

    // Randomized traffic over a small address window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      ra = '{cs: $urandom_range(0, 7) != 0, rd: 1'($urandom_range(0, 1)), wr: $urandom_range(0, 2) == 0,
             addr: 8'($urandom_range(0, 7)), be: 4'($urandom), wd: $urandom};
      rb = '{cs: $urandom_range(0, 7) != 0, rd: 1'($urandom_range(0, 1)), wr: $urandom_range(0, 2) == 0,
             addr: 8'($urandom_range(0, 7)), be: 4'($urandom), wd: $urandom};
      drive(ra, rb);
      step();
      sb_check();
    end
    drive(IDLE, IDLE);
    repeat (LAT + 1) begin
      step();
      sb_check();
    end
    check("rand_pend_a", q_a.size(), 0);
    check("rand_pend_b", q_b.size(), 0);
    check("rand_coll", {16'h0, collision_cnt}, m_coll);
    sb_on = 0;

    // Reset with a read in flight, then a reset pulse part-way through the fill.
    drive(mk_rd(8'h10), mk_rd(8'h20));
    step();
    reset_n = 1'b0;
    drive(IDLE, IDLE);
    step();
    check_reset_outputs("rst_flight");
    reset_n = 1'b1;
    spurious = 0;
    repeat (100) begin
      if (readdatavalid_a || readdatavalid_b) spurious++;
      step();
    end
    check("flight_discard", spurious, 0);
    check1("mid_clear_wait", waitrequest_a, 1'b1);
    reset_n = 1'b0;
    step();
    check_reset_outputs("rst_mid");
    reset_n = 1'b1;
    model_clear();
    count_clear(n_clear, spurious);
    check("refill_len", n_clear, 256);
    check("refill_quiet", spurious, 0);
    check1("refill_init", init_done, 1'b1);

    // Contents written before the second reset are zero after the refill.
    drive(mk_rd(8'h10), mk_rd(8'h05));
    step();
    drive(IDLE, IDLE);
    repeat (LAT - 1) step();
    check1("post_valid_a", readdatavalid_a, 1'b1);
    check1("post_valid_b", readdatavalid_b, 1'b1);
    check("post_data_a", readdata_a, m_mem[8'h10]);
    check("post_data_b", readdata_b, m_mem[8'h05]);
    check("post_coll", {16'h0, collision_cnt}, m_coll);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
